load_monitor: RTL and testbench
===============================

# load_monitor

Parametrised elevator-car load monitor, successor to the fixed 6-flip weight limiter. It counts passenger entry and exit events with edge detection and an up/down saturating counter. It raises an overload flag with time-based hysteresis on release and drives the door-hold request consumed by the door controller. It sits between the car's load sensors and the elevator main FSM.

## Interface
- CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W-1 > MAX_LOAD
- MAX_LOAD, 5, max permitted occupancy; overload when count > MAX_LOAD
- WARN_LEVEL, 4, near-full threshold; must be ≤ MAX_LOAD
- CLEAR_CYCLES, 8, consecutive in-limit cycles required before overload releases; must be ≥ 1
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enter  input  1  level from entry sensor; each rising edge = +1 passenger
- leave  input  1  level from exit sensor; each rising edge = −1 passenger
- load_reset  input  1  synchronous clear of count, FSM and error flag
- count  output  CNT_W  current occupancy
- near_full  output  1  count ≥ WARN_LEVEL and not overloaded
- weight_limit_exceeded  output  1  overload flag (OVERLOAD or CLEARING)
- door_hold  output  1  request doors stay open; high only in OVERLOAD
- underflow_err  output  1  sticky; leave edge seen at count 0

## Operation
- Edge detect: enter_q/leave_q register the sampled inputs each cycle, including during load_reset. inc = enter & ~enter_q; dec = leave & ~leave_q.
- Counter next value:
  - inc & dec: unchanged.
  - inc only: +1, saturating at 2^CNT_W-1.
  - dec only at 0: stays 0 and sets underflow_err.
  - dec only otherwise: −1.
- No wrap-around in either direction.
- FSM states NORMAL, OVERLOAD, CLEARING. All decisions use next count (nc).
  - NORMAL → OVERLOAD when nc > MAX_LOAD.
  - OVERLOAD → CLEARING when nc ≤ MAX_LOAD; clear_timer ← 0.
  - CLEARING → OVERLOAD when nc > MAX_LOAD.
  - CLEARING, nc ≤ MAX_LOAD: clear_timer +1. At the edge where clear_timer = CLEAR_CYCLES-1 the FSM goes → NORMAL.
  - clear_timer width is clog2(CLEAR_CYCLES)+1 bits. The timer is don't-care outside CLEARING.
- Outputs are decoded from registered state and count:
  - weight_limit_exceeded = (state ≠ NORMAL)
  - door_hold = (state = OVERLOAD)
  - near_full = (count ≥ WARN_LEVEL) & (state = NORMAL)
- load_reset has priority over all events in the same cycle. It sets count 0, state NORMAL and underflow_err 0. Edge registers still update, so a sensor held high through load_reset produces no event afterward.
- Reset values (rst_n low, asynchronous): count 0, state NORMAL, clear_timer 0, enter_q 0, leave_q 0, underflow_err 0. Hence near_full 0, weight_limit_exceeded 0, door_hold 0.
- A sensor already high at reset release counts as one event on the first clock edge.

## Timing
- Zero-cycle latency, registered: an input first sampled high at edge k updates count and state at edge k, so outputs change just after edge k.
- Overload assertion appears in the same cycle count reaches MAX_LOAD+1.
- Release: the leave edge at edge k moves the FSM to CLEARING. weight_limit_exceeded falls after edge k+CLEAR_CYCLES, provided no re-entry occurs.
- door_hold drops at edge k, i.e. doors may close once the load is legal. The flag stays up through CLEARING.
- A level held high counts once. A new event requires the input to be sampled low for at least one cycle.
- Async reset mid-CLEARING returns to NORMAL immediately with no pending release.

## Test plan
- Reset, then 5 enter pulses (1 cycle high, 1 low each), defaults → count 5, near_full 1, weight_limit_exceeded 0. A 6th pulse → count 6, weight_limit_exceeded 1 and door_hold 1 in the same cycle, near_full 0.
- From count 6, one leave pulse at edge k → count 5, door_hold 0 at k, weight_limit_exceeded 1 through k+7 and 0 after k+8. Repeat with an enter pulse at k+4 → back to OVERLOAD at k+4, door_hold 1.
- enter and leave rising together at count 3 → count stays 3. enter held high for 20 cycles → count +1 only.
- Leave pulse at count 0 → count 0, underflow_err 1 and sticky. load_reset with enter rising in the same cycle → count 0, underflow_err 0, and no count on the following cycles while enter stays high.
- CNT_W=3, MAX_LOAD=5: 9 enter pulses → count saturates at 7, overload set. 7 leave pulses → count 0 with no wrap.
- Assert rst_n low asynchronously mid-CLEARING (count 5) → all outputs 0 and count 0 before the next clock edge. After release, the next enter pulse gives count 1, state NORMAL.

Source files
------------

// File: rtl/load_monitor.sv
// rtl/load_monitor.sv - elevator car occupancy counter with overload hysteresis and door-hold request
module load_monitor #(
    parameter int CNT_W        = 4,
    parameter int MAX_LOAD     = 5,
    parameter int WARN_LEVEL   = 4,
    parameter int CLEAR_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic             leave,
    input  logic             load_reset,
    output logic [CNT_W-1:0] count,
    output logic             near_full,
    output logic             weight_limit_exceeded,
    output logic             door_hold,
    output logic             underflow_err
);

    localparam int TMR_W = $clog2(CLEAR_CYCLES) + 1;

    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_LOAD);
    localparam logic [CNT_W-1:0] WARN_C  = CNT_W'(WARN_LEVEL);
    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] CLR_END = TMR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        NORMAL,
        OVERLOAD,
        CLEARING
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   clear_timer;
    logic               enter_q;
    logic               leave_q;

    logic               inc;
    logic               dec;
    logic               underflow_hit;
    logic               over_next;
    logic [CNT_W-1:0]   nc;

    assign inc = enter & ~enter_q;
    assign dec = leave & ~leave_q;
    assign underflow_hit = dec & ~inc & (count == '0);

    // Simultaneous entry and exit cancel; both directions saturate instead of wrapping.
    always_comb begin
        nc = count;
        if (inc && !dec) begin
            if (count != CNT_TOP) nc = count + 1'b1;
        end else if (dec && !inc) begin
            if (count != '0) nc = count - 1'b1;
        end
    end

    assign over_next = (nc > MAX_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            state         <= NORMAL;
            clear_timer   <= '0;
            enter_q       <= 1'b0;
            leave_q       <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            // Edge registers keep tracking during load_reset so a held sensor is not recounted.
            enter_q <= enter;
            leave_q <= leave;
            if (load_reset) begin
                count         <= '0;
                state         <= NORMAL;
                clear_timer   <= '0;
                underflow_err <= 1'b0;
            end else begin
                count <= nc;
                if (underflow_hit) underflow_err <= 1'b1;
                case (state)
                    NORMAL: begin
                        if (over_next) state <= OVERLOAD;
                    end
                    OVERLOAD: begin
                        if (!over_next) begin
                            state       <= CLEARING;
                            clear_timer <= '0;
                        end
                    end
                    CLEARING: begin
                        if (over_next) begin
                            state <= OVERLOAD;
                        end else if (clear_timer == CLR_END) begin
                            state <= NORMAL;
                        end else begin
                            clear_timer <= clear_timer + 1'b1;
                        end
                    end
                    default: state <= NORMAL;
                endcase
            end
        end
    end

    assign weight_limit_exceeded = (state != NORMAL);
    assign door_hold             = (state == OVERLOAD);
    assign near_full             = (count >= WARN_C) && (state == NORMAL);

endmodule

// File: tb/tb_load_monitor.sv
// tb/tb_load_monitor.sv - directed vector bench for load_monitor
module tb_load_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enter, leave, load_reset;
    logic [3:0] count;
    logic       near_full, wle, door_hold, uf_err;

    logic       enter1, leave1, load_reset1;
    logic [2:0] count1;
    logic       near_full1, wle1, door_hold1, uf_err1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    load_monitor dut (
        .clk(clk), .rst_n(rst_n), .enter(enter), .leave(leave), .load_reset(load_reset),
        .count(count), .near_full(near_full), .weight_limit_exceeded(wle),
        .door_hold(door_hold), .underflow_err(uf_err)
    );

    load_monitor #(.CNT_W(3), .MAX_LOAD(5), .WARN_LEVEL(4), .CLEAR_CYCLES(8)) dut_small (
        .clk(clk), .rst_n(rst_n), .enter(enter1), .leave(leave1), .load_reset(load_reset1),
        .count(count1), .near_full(near_full1), .weight_limit_exceeded(wle1),
        .door_hold(door_hold1), .underflow_err(uf_err1)
    );

    typedef struct {
        logic       e;
        logic       l;
        logic       r;
        logic [3:0] cnt;
        logic       nf;
        logic       wle;
        logic       dh;
        logic       uf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic l, input logic r, input int c,
                       input logic nf, input logic w, input logic dh, input logic uf);
        vec_t v;
        v.e = e; v.l = l; v.r = r; v.cnt = 4'(c);
        v.nf = nf; v.wle = w; v.dh = dh; v.uf = uf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs between edges, then sample 1 time unit after the rising edge.
    task automatic step(input logic e, input logic l, input logic r);
        enter = e; leave = l; load_reset = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic e, input logic l);
        enter1 = e; leave1 = l; load_reset1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic int pack0();
        return {24'd0, count, near_full, wle, door_hold, uf_err};
    endfunction

    initial begin
        // {count, near_full, wle, door_hold, underflow_err} per cycle
        for (int i = 1; i <= 5; i++) begin
            add(1, 0, 0, i, i >= 4, 0, 0, 0);
            add(0, 0, 0, i, i >= 4, 0, 0, 0);
        end
        add(1, 0, 0, 6, 0, 1, 1, 0);
        add(0, 0, 0, 6, 0, 1, 1, 0);
        add(0, 1, 0, 5, 0, 1, 0, 0);
        for (int i = 1; i <= 7; i++) add(0, 0, 0, 5, 0, 1, 0, 0);
        add(0, 0, 0, 5, 1, 0, 0, 0);
        add(1, 0, 0, 6, 0, 1, 1, 0);
        add(0, 0, 0, 6, 0, 1, 1, 0);
        add(0, 1, 0, 5, 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 5, 0, 1, 0, 0);
        add(1, 0, 0, 6, 0, 1, 1, 0);
        add(0, 0, 0, 6, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            add(1, 0, 0, i, 0, 0, 0, 0);
            add(0, 0, 0, i, 0, 0, 0, 0);
        end
        add(1, 1, 0, 3, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) add(1, 0, 0, 4, 1, 0, 0, 0);
        add(0, 0, 0, 4, 1, 0, 0, 0);
        for (int i = 3; i >= 0; i--) begin
            add(0, 1, 0, i, i >= 4, 0, 0, 0);
            add(0, 0, 0, i, i >= 4, 0, 0, 0);
        end
        add(0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        enter = 1'b0; leave = 1'b0; load_reset = 1'b0;
        enter1 = 1'b0; leave1 = 1'b0; load_reset1 = 1'b0;
        @(posedge clk);
        #1;
        check("reset_dut", pack0(), 0);
        check("reset_small", {count1, near_full1, wle1, door_hold1, uf_err1}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].e, vecs[i].l, vecs[i].r);
            check($sformatf("vec%0d", i), pack0(),
                  {24'd0, vecs[i].cnt, vecs[i].nf, vecs[i].wle, vecs[i].dh, vecs[i].uf});
        end

        // Saturation and no-wrap on the 3-bit counter variant.
        for (int i = 1; i <= 9; i++) begin
            step1(1, 0);
            check($sformatf("sat_cnt%0d", i), count1, (i > 7) ? 7 : i);
            check($sformatf("sat_wle%0d", i), wle1, i >= 6);
            step1(0, 0);
        end
        for (int i = 1; i <= 7; i++) begin
            step1(0, 1);
            check($sformatf("drain_cnt%0d", i), count1, 7 - i);
            step1(0, 0);
        end
        check("drain_uf", uf_err1, 0);

        // Async reset while CLEARING at count 5.
        step(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0);
            step(0, 0, 0);
        end
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("pre_areset", pack0(), {24'd0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0});
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_mid_cycle", pack0(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0);
        check("post_areset_enter", pack0(), {24'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        check("post_areset_idle", pack0(), {24'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
